// File: rtl/arb4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package arb4_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] RESET_LAST = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/decoder_2_to_4_2.sv
// Dataflow 2-to-4 decoder; A is the MSB, B the LSB of the select code.
// Combinational, no backpressure.
module decoder_2_to_4_2 (
  input  logic       A,
  input  logic       B,
  output logic [3:0] Y
);

  assign Y[0] = ~A & ~B;
  assign Y[1] = ~A &  B;
  assign Y[2] =  A & ~B;
  assign Y[3] =  A &  B;

endmodule

// File: rtl/rr_next_pick.sv
// Round-robin search: first set request after the last owner, wrapping to the last owner itself.
// Purely combinational; pick is meaningless when any=0.
module rr_next_pick
  import arb4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   pick,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate inward so the nearest one overwrites.
  always_comb begin
    pick = last;
    cand = last;
    any  = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last + IDX_W'(k);
      if (req[cand]) begin
        pick = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin 4-way arbiter with hold timeout; grant appears 1 cycle after request.
// Owner keeps the grant until done, withdrawal or MAX_HOLD; one idle cycle separates grants.
module rr_arbiter_4
  import arb4_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic HOLD_EN = (MAX_HOLD != 0);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmo_q, tmo_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] dec;
  logic [IDX_W-1:0]   pick;
  logic               any;
  logic               expire;
  logic               rel;

  rr_next_pick u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .any  (any)
  );

  decoder_2_to_4_2 u_dec (
    .A (idx_d[1]),
    .B (idx_d[0]),
    .Y (dec)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    expire  = HOLD_EN && (cnt_q == CNT_LAST);
    rel     = done || !req[idx_q] || expire;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          idx_d   = pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (rel) begin
          state_d = IDLE;
          last_d  = idx_q;
          // Timeout is reported only when expiry is the sole release reason.
          tmo_d   = expire && !done && req[idx_q];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_d = (state_d == GRANT) ? dec : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= RESET_LAST;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      grant_q <= grant_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = (state_q == GRANT);
  assign timeout     = tmo_q;

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one 4-way resource between four requesters.
- Produces a registered 2-bit grant index and its one-hot decode; the one-hot grant drives the resource-select lines.
- Holds a grant until the owner releases it or a hold timeout expires, then rotates priority.
- Sits between requesting masters and any 4-way select, mux, or enable bank.

Parameters:
MAX_HOLD, 16, maximum cycles a grant may be held before forced release; 0 disables the timeout
CNT_W, $clog2(MAX_HOLD+1) (minimum 1), width of the hold counter; derived, not overridden

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  4  request vector; bit i = requester i wants the resource
done  input  1  owner releases the resource this cycle; ignored when no grant is active
grant  output  4  one-hot grant, registered; all zero when idle
grant_idx  output  2  encoded index of the current owner; valid only when grant_valid=1
grant_valid  output  1  1 while a grant is active
timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; grant=4'b0000, grant_idx=2'b00, grant_valid=0, timeout=0, hold counter=0.
  - last-owner pointer=3, so requester 0 has top priority after reset.
  - Reset mid-grant drops grant at that same edge; no timeout pulse is generated.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, pick the first set bit searching last+1, last+2, last+3, last (mod 4).
  - Next edge: state=GRANT, grant_idx=pick, grant=decode(pick), grant_valid=1, counter=0.
  - Latency is 1 cycle from req sampled high to grant visible.
- GRANT: counter increments each cycle, saturating at MAX_HOLD. Release occurs when any of these holds:
  - (a) done=1;
  - (b) req[grant_idx]=0 (requester withdrew);
  - (c) MAX_HOLD!=0 and counter==MAX_HOLD-1 (the grant has been held MAX_HOLD cycles).
- On release (next edge):
  - state=IDLE, grant=0, grant_valid=0, last=grant_idx.
  - grant_idx keeps its last value (don't-care to consumers).
- timeout=1 for exactly one cycle, coincident with the first IDLE cycle, only when release cause is (c) alone.
  - done=1 or req withdrawal in the same cycle as expiry suppresses the timeout.
- Mandatory one-cycle idle bubble between consecutive grants; grants never switch owner directly. This guarantees a break-before-make select.
- Requests arriving during GRANT are only evaluated in IDLE. A requester that keeps req high after timeout re-enters arbitration with lowest priority.
- Invariants:
  - grant is always either zero or one-hot.
  - grant == decode(grant_idx) whenever grant_valid=1.
  - grant_valid == |grant.
- done while in IDLE has no effect.

Decomposition:
- Package arb4_pkg holds:
  - state enum {IDLE, GRANT};
  - constants NUM_REQ=4, IDX_W=2, RESET_LAST=2'd3.
- Sub-module rr_next_pick (combinational): inputs req[3:0], last[1:0]; outputs pick[1:0], any.
- grant decode reuses the team's dataflow 2-to-4 decoder decoder_2_to_4_2 (A=grant_idx[1], B=grant_idx[0]), gated by grant_valid and registered.

Test Plan:
- Reset then req=4'b1111, done pulsed 1 cycle after each grant:
  - grants in order 0001, 0010, 0100, 1000, 0001;
  - each grant separated by exactly one idle cycle.
- req=4'b0100 only, held high, done never, MAX_HOLD=16:
  - grant=0100 for 16 cycles, then grant=0;
  - timeout=1 on that single idle cycle;
  - re-granted 0100 the next cycle.
- Owner 1 granted, then req=4'b1010 with done=1 on the expiry cycle: timeout stays 0, next grant=1000.
- Grant active on requester 2, req[2] dropped with no done: grant=0 next edge, last=2, then requester 3 wins over 0.
- rst asserted while grant=0010 and counter=5:
  - next edge: all outputs zero, timeout=0;
  - after rst deasserts with req=4'b0011, requester 0 wins.
- MAX_HOLD=0, req=4'b0001 held 100 cycles: grant stays 0001 throughout, timeout never asserted.
